hwce_stream_sequencer: RTL and testbench

- Parametrised successor of the HWCE wrapper FSM. It sequences the weight-load, preload-stream start, AXI preload wait, run-stream start and run phases of the convolution engine.
- New over the previous generation:
  - run-time per-phase stream masks instead of hard-wired stream groups;
  - a true per-stream req/ready handshake (req held until accepted);
  - multi-job looping without CPU intervention;
  - abort;
  - an optional watchdog.
- Sits between the HWCE register file/controller and the streamer start ports.

---
 rtl/hwce_seq_pkg.sv | 17 +
 rtl/hwce_seq_handshake.sv | 38 +++
 rtl/hwce_stream_sequencer.sv | 166 ++++++++++++++++
 tb/tb_hwce_stream_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwce_seq_pkg.sv
// Shared definitions for the HWCE stream sequencer: state encoding and default sizing.
package hwce_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WLOAD    = 3'd1,
        S_PRELOAD  = 3'd2,
        S_AXI_WAIT = 3'd3,
        S_RUN_REQ  = 3'd4,
        S_RUN      = 3'd5,
        S_ERROR    = 3'd6
    } seq_state_e;

    localparam int unsigned DEFAULT_N_STREAMS = 5;
    localparam int unsigned DEFAULT_JOB_W     = 8;

endpackage

// File: rtl/hwce_seq_handshake.sv
// Per-phase start tracker: loads a stream mask, holds each request until its ready is seen.
module hwce_seq_handshake
    import hwce_seq_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N_STREAMS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] mask,
    input  logic [N-1:0] ready,
    input  logic         clear,
    output logic [N-1:0] req,
    output logic         all_done
);

    logic [N-1:0] pending;
    logic [N-1:0] pending_nxt;

    // Ready on a stream with no outstanding request simply has nothing to clear.
    always_comb begin
        pending_nxt = pending & ~ready;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pending <= '0;
        end else if (load) begin
            pending <= mask;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign req      = pending;
    assign all_done = (pending_nxt == '0);

endmodule

// File: rtl/hwce_stream_sequencer.sv
// HWCE job sequencer: weight load, preload start, AXI wait, run start, run; loops over n_jobs.
// Optional watchdog enabled by defining HWCE_SEQ_TIMEOUT_EN.
module hwce_stream_sequencer
    import hwce_seq_pkg::*;
#(
    parameter int unsigned N_STREAMS      = DEFAULT_N_STREAMS,
    parameter int unsigned JOB_W          = DEFAULT_JOB_W,
    parameter int unsigned TIMEOUT_W      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [JOB_W-1:0]     n_jobs_i,
    input  logic [N_STREAMS-1:0] preload_mask_i,
    input  logic [N_STREAMS-1:0] run_mask_i,
    input  logic                 done_weightload_i,
    input  logic                 axi_done_preload_i,
    input  logic                 done_ctrl_i,
    input  logic                 abort_i,
    input  logic [N_STREAMS-1:0] ready_start_i,
    output logic [N_STREAMS-1:0] req_start_o,
    output logic                 engine_start_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [JOB_W-1:0]     job_idx_o,
    output logic [2:0]           state_o,
    output logic                 err_timeout_o
);

    if (TIMEOUT_CYCLES == 0 || (TIMEOUT_CYCLES >> TIMEOUT_W) != 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1 .. 2**TIMEOUT_W-1");
    end

    seq_state_e           state, state_nxt, norm_nxt;
    logic [JOB_W-1:0]     job_idx, job_nxt, last_idx;
    logic [N_STREAMS-1:0] pre_mask, run_mask, hs_mask, hs_req;
    logic                 hs_load, hs_clear, hs_all_done;
    logic                 latch, eng_nxt, done_nxt, go, wd_hit;
    logic                 eng_q, done_q, busy_q, run_seen_q;

    // Normal-flow next state and side effects, before abort/watchdog overrides.
    always_comb begin
        norm_nxt = state;
        job_nxt  = job_idx;
        eng_nxt  = 1'b0;
        done_nxt = 1'b0;
        latch    = 1'b0;
        case (state)
            S_IDLE: if (start_i) begin
                norm_nxt = S_WLOAD;
                latch    = 1'b1;
                job_nxt  = '0;
                eng_nxt  = 1'b1;
            end
            S_WLOAD:    if (done_weightload_i)  norm_nxt = S_PRELOAD;
            S_PRELOAD:  if (hs_all_done)        norm_nxt = S_AXI_WAIT;
            S_AXI_WAIT: if (axi_done_preload_i) norm_nxt = S_RUN_REQ;
            S_RUN_REQ:  if (hs_all_done)        norm_nxt = S_RUN;
            // done_ctrl_i may still be high from the previous job on the first RUN cycle.
            S_RUN: if (run_seen_q && done_ctrl_i) begin
                if (job_idx == last_idx) begin
                    norm_nxt = S_IDLE;
                    done_nxt = 1'b1;
                end else begin
                    norm_nxt = S_WLOAD;
                    job_nxt  = job_idx + 1'b1;
                    eng_nxt  = 1'b1;
                end
            end
            S_ERROR: norm_nxt = S_ERROR;
            default: norm_nxt = S_IDLE;
        endcase
    end

    // A watchdog hit only happens on a cycle with no progress, so it has no side effects to cancel.
    always_comb begin
        go        = ~abort_i;
        state_nxt = abort_i ? S_IDLE : (wd_hit ? S_ERROR : norm_nxt);
        hs_load   = go && (state_nxt != state)
                    && (state_nxt == S_PRELOAD || state_nxt == S_RUN_REQ);
        hs_mask   = (state_nxt == S_PRELOAD) ? pre_mask : run_mask;
        hs_clear  = (state_nxt == S_IDLE) || (state_nxt == S_ERROR);
    end

    hwce_seq_handshake #(.N(N_STREAMS)) u_handshake (
        .clk      (clk),
        .rst      (rst),
        .load     (hs_load),
        .mask     (hs_mask),
        .ready    (ready_start_i),
        .clear    (hs_clear),
        .req      (hs_req),
        .all_done (hs_all_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            job_idx    <= '0;
            last_idx   <= '0;
            pre_mask   <= '0;
            run_mask   <= '0;
            eng_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            run_seen_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            job_idx    <= go ? job_nxt : job_idx;
            eng_q      <= go && eng_nxt;
            done_q     <= go && done_nxt;
            busy_q     <= (state_nxt != S_IDLE);
            run_seen_q <= (state == S_RUN);
            if (go && latch) begin
                pre_mask <= preload_mask_i;
                run_mask <= run_mask_i;
                last_idx <= (n_jobs_i == '0) ? '0 : n_jobs_i - 1'b1;
            end
        end
    end

`ifdef HWCE_SEQ_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 wd_counting, wd_accept, err_q;

    always_comb begin
        wd_counting = (state != S_IDLE) && (state != S_ERROR);
        wd_accept   = |(hs_req & ready_start_i);
        wd_hit      = wd_counting && (norm_nxt == state) && !wd_accept && (wd_cnt == WD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (abort_i || !wd_counting || state_nxt != state || wd_accept) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (abort_i) begin
                err_q <= 1'b0;
            end else if (wd_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout_o = err_q;
`else
    assign wd_hit        = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    assign req_start_o    = hs_req;
    assign engine_start_o = eng_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign job_idx_o      = job_idx;
    assign state_o        = state;

endmodule

// File: tb/tb_hwce_stream_sequencer.sv
// Bench for hwce_stream_sequencer: directed scenarios, cycle model plus literal end-of-scenario checks.
module tb_hwce_stream_sequencer;

    localparam int NS = 5;
    localparam int JW = 8;
    localparam int TO = 16;
    localparam int OW = 20;

    typedef struct packed {
        logic [2:0]    st;
        logic [NS-1:0] req;
        logic          eng;
        logic          busy;
        logic          done;
        logic [JW-1:0] job;
        logic          err;
    } out_t;

    typedef struct packed {
        logic          rst;
        logic          start;
        logic [JW-1:0] n;
        logic [NS-1:0] pre;
        logic [NS-1:0] run;
        logic          wl;
        logic          axi;
        logic          dc;
        logic          abort;
        logic [NS-1:0] ready;
    } in_t;

    logic          clk = 1'b0;
    logic          rst, start_i, done_weightload_i, axi_done_preload_i, done_ctrl_i, abort_i;
    logic [JW-1:0] n_jobs_i;
    logic [NS-1:0] preload_mask_i, run_mask_i, ready_start_i, req_start_o;
    logic          engine_start_o, busy_o, done_o, err_timeout_o;
    logic [JW-1:0] job_idx_o;
    logic [2:0]    state_o;

    always #5 clk = ~clk;

    hwce_stream_sequencer #(
        .N_STREAMS(NS), .JOB_W(JW), .TIMEOUT_W(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .n_jobs_i(n_jobs_i),
        .preload_mask_i(preload_mask_i), .run_mask_i(run_mask_i),
        .done_weightload_i(done_weightload_i), .axi_done_preload_i(axi_done_preload_i),
        .done_ctrl_i(done_ctrl_i), .abort_i(abort_i), .ready_start_i(ready_start_i),
        .req_start_o(req_start_o), .engine_start_o(engine_start_o), .busy_o(busy_o),
        .done_o(done_o), .job_idx_o(job_idx_o), .state_o(state_o), .err_timeout_o(err_timeout_o)
    );

    logic [OW-1:0] exp_q[$];
    int nvec = 0;
    int nfail = 0;
    int eng_cnt, done_cnt, rreq_cnt, max_job;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases by spec number, streams outstanding as a bit set.
    int            m_st, m_last, m_job, m_run_age, m_wd;
    logic [NS-1:0] m_pend, m_pre, m_run;
    logic          m_eng, m_done, m_err;

    task automatic model_step(input in_t v);
        out_t          e;
        int            ns;
        logic [NS-1:0] np;
        logic          acc;
        m_eng  = 1'b0;
        m_done = 1'b0;
        if (v.rst) begin
            m_st = 0; m_pend = '0; m_pre = '0; m_run = '0; m_last = 0;
            m_job = 0; m_run_age = 0; m_wd = 0; m_err = 1'b0;
        end else if (v.abort) begin
            m_st = 0; m_pend = '0; m_err = 1'b0; m_wd = 0;
        end else begin
            ns  = m_st;
            np  = m_pend;
            acc = 1'b0;
            case (m_st)
                0: if (v.start) begin
                    m_pre = v.pre; m_run = v.run;
                    m_last = (v.n == 0) ? 0 : int'(v.n) - 1;
                    m_job = 0; ns = 1; m_eng = 1'b1;
                end
                1: if (v.wl) begin ns = 2; np = m_pre; end
                2, 4: begin
                    acc = |(m_pend & v.ready);
                    np  = m_pend & ~v.ready;
                    if (np == '0) begin
                        ns = (m_st == 2) ? 3 : 5;
                        m_run_age = 0;
                    end
                end
                3: if (v.axi) begin ns = 4; np = m_run; end
                5: begin
                    if (m_run_age > 0 && v.dc) begin
                        if (m_job == m_last) begin
                            ns = 0; m_done = 1'b1;
                        end else begin
                            m_job++; ns = 1; m_eng = 1'b1;
                        end
                    end
                    m_run_age++;
                end
                default: ;
            endcase
`ifdef HWCE_SEQ_TIMEOUT_EN
            if (m_st != 0 && m_st != 6 && ns == m_st && !acc) begin
                m_wd++;
                if (m_wd >= TO) begin
                    ns = 6; np = '0; m_err = 1'b1; m_wd = 0;
                end
            end else begin
                m_wd = 0;
            end
`endif
            m_st   = ns;
            m_pend = np;
        end
        e.st   = m_st[2:0];
        e.req  = m_pend;
        e.eng  = m_eng;
        e.busy = (m_st != 0);
        e.done = m_done;
        e.job  = m_job[JW-1:0];
        e.err  = m_err;
        exp_q.push_back(e);
    endtask

    // Compare process: one expectation per clock, checked 2 time units after the edge.
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = out_t'(exp_q.pop_front());
                chk("state_o",        int'(state_o),        int'(e.st));
                chk("req_start_o",    int'(req_start_o),    int'(e.req));
                chk("engine_start_o", int'(engine_start_o), int'(e.eng));
                chk("busy_o",         int'(busy_o),         int'(e.busy));
                chk("done_o",         int'(done_o),         int'(e.done));
                chk("job_idx_o",      int'(job_idx_o),      int'(e.job));
                chk("err_timeout_o",  int'(err_timeout_o),  int'(e.err));
                eng_cnt  += int'(engine_start_o);
                done_cnt += int'(done_o);
                rreq_cnt += (state_o == 3'd4) ? 1 : 0;
                if (int'(job_idx_o) > max_job) max_job = int'(job_idx_o);
            end
        end
    end

    in_t cur;

    task automatic apply(input in_t v);
        rst = v.rst; start_i = v.start; n_jobs_i = v.n;
        preload_mask_i = v.pre; run_mask_i = v.run;
        done_weightload_i = v.wl; axi_done_preload_i = v.axi;
        done_ctrl_i = v.dc; abort_i = v.abort; ready_start_i = v.ready;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            apply(cur);
            model_step(cur);
        end
    endtask

    task automatic clr_mon();
        eng_cnt = 0; done_cnt = 0; rreq_cnt = 0; max_job = 0;
    endtask

    task automatic start_job(input int n, input logic [NS-1:0] pre, input logic [NS-1:0] run);
        cur.start = 1'b1; cur.n = JW'(n); cur.pre = pre; cur.run = run;
        step(1);
        cur.start = 1'b0;
    endtask

    task automatic pulse_wl();
        cur.wl = 1'b1; step(1); cur.wl = 1'b0;
    endtask

    task automatic pulse_axi();
        cur.axi = 1'b1; step(1); cur.axi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        cur = '0;
        cur.rst = 1'b1;
        apply(cur);
        clr_mon();
        step(3);
        cur.rst = 1'b0;
        step(2);
        chk("reset_state_lit", int'(state_o), 0);
        chk("reset_busy_lit", int'(busy_o), 0);

        // Single job, all readies high.
        clr_mon();
        cur.ready = '1;
        start_job(1, 5'b10000, 5'b01111);
        step(2);
        pulse_wl();
        step(1);
        step(1);
        pulse_axi();
        step(1);
        cur.dc = 1'b1; step(2); cur.dc = 1'b0;
        step(3);
        chk("s1_eng_cnt_lit", eng_cnt, 1);
        chk("s1_done_cnt_lit", done_cnt, 1);
        chk("s1_end_state_lit", int'(state_o), 0);

        // Staggered readies, empty preload mask, n_jobs=0, start while busy.
        clr_mon();
        cur.ready = '0;
        start_job(0, 5'b00000, 5'b01111);
        cur.start = 1'b1; step(1); cur.start = 1'b0;
        pulse_wl();
        step(1);
        pulse_axi();
        for (int k = 1; k <= 11; k++) begin
            cur.ready[0] = (k >= 3);
            cur.ready[1] = (k >= 5);
            cur.ready[2] = (k >= 5);
            cur.ready[3] = (k >= 9);
            cur.ready[4] = (k >= 2);
            step(1);
        end
        cur.dc = 1'b1; step(3); cur.dc = 1'b0;
        step(3);
        chk("s2_runreq_cycles_lit", rreq_cnt, 9);
        chk("s2_eng_cnt_lit", eng_cnt, 1);
        chk("s2_done_cnt_lit", done_cnt, 1);

        // Three jobs back to back.
        clr_mon();
        cur.ready = '1;
        start_job(3, 5'b00011, 5'b11100);
        for (int j = 0; j < 3; j++) begin
            step(1);
            pulse_wl();
            step(1);
            pulse_axi();
            step(1);
            cur.dc = 1'b1; step(2); cur.dc = 1'b0;
        end
        step(3);
        chk("s3_eng_cnt_lit", eng_cnt, 3);
        chk("s3_done_cnt_lit", done_cnt, 1);
        chk("s3_max_job_lit", max_job, 2);

        // Abort in AXI_WAIT, abort with a pending request, abort+start in IDLE, then a clean job.
        clr_mon();
        cur.ready = 5'b00001;
        start_job(1, 5'b00001, 5'b00110);
        pulse_wl();
        step(1);
        step(2);
        cur.abort = 1'b1; step(1); cur.abort = 1'b0;
        step(2);
        chk("s4_abort_axi_state_lit", int'(state_o), 0);
        start_job(1, 5'b00001, 5'b00110);
        pulse_wl();
        step(1);
        pulse_axi();
        cur.ready = 5'b00010;
        step(2);
        cur.abort = 1'b1; step(1); cur.abort = 1'b0;
        cur.ready = '0;
        step(2);
        chk("s4_abort_req_lit", int'(req_start_o), 0);
        cur.abort = 1'b1; cur.start = 1'b1; step(1);
        cur.abort = 1'b0; cur.start = 1'b0;
        step(2);
        cur.ready = '1;
        start_job(1, 5'b00001, 5'b00110);
        step(1);
        pulse_wl();
        step(1);
        pulse_axi();
        step(1);
        cur.dc = 1'b1; step(2); cur.dc = 1'b0;
        step(3);
        chk("s4_done_cnt_lit", done_cnt, 1);
        chk("s4_eng_cnt_lit", eng_cnt, 3);

        // Reset in the middle of a job.
        clr_mon();
        start_job(2, 5'b00001, 5'b00001);
        pulse_wl();
        step(2);
        cur.rst = 1'b1; step(1); cur.rst = 1'b0;
        step(3);
        chk("s5_done_cnt_lit", done_cnt, 0);
        chk("s5_state_lit", int'(state_o), 0);

`ifdef HWCE_SEQ_TIMEOUT_EN
        // Weight load never completes: watchdog trips, abort recovers.
        clr_mon();
        start_job(1, 5'b00001, 5'b00001);
        step(20);
        chk("s6_error_state_lit", int'(state_o), 6);
        chk("s6_err_flag_lit", int'(err_timeout_o), 1);
        cur.abort = 1'b1; step(1); cur.abort = 1'b0;
        step(2);
        chk("s6_err_clear_lit", int'(err_timeout_o), 0);
        chk("s6_idle_lit", int'(state_o), 0);
`endif

        step(2);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
